spi_regfile_peripheral: RTL
===========================

Name: spi_regfile_peripheral

Overview:
- Parametrised SPI register-file peripheral: successor to the byte-wide, sck-clocked SPI memory peripheral.
- All logic runs on one system clock; cs/sck/mosi are oversampled through synchronisers.
- Adds configurable data and address width, all four SPI modes, and read/write bursts.
- Adds a host-side parallel port so on-chip logic can access the same register file.

Parameters:
- DATA_W, 8: frame and register width in bits.
- ADDR_W, 7: register address width; must be <= DATA_W-1; DEPTH = 2**ADDR_W.
- CPOL, 0: sck idle level.
- CPHA, 0: 0 = sample on leading edge / shift on trailing edge; 1 = shift on leading edge / sample on trailing edge.

Ports:
- clk  in  1  system clock; f_clk >= 8*f_sck.
- reset_n  in  1  asynchronous, active-low reset.
- cs  in  1  SPI chip select, active-low, asynchronous to clk.
- sck  in  1  SPI clock, asynchronous to clk.
- mosi  in  1  SPI data in, MSB first.
- miso  out  1  SPI data out, MSB first; 0 while cs high.
- hostAddr  in  ADDR_W  host register address.
- hostWrData  in  DATA_W  host write data.
- hostWe  in  1  host write enable.
- hostRdData  out  DATA_W  registered mem[hostAddr].
- spiWrStrobe  out  1  one-clk pulse per completed SPI register write.
- spiWrAddr  out  ADDR_W  address of that write.
- spiWrData  out  DATA_W  data of that write.
- busy  out  1  synchronised cs active.

Behaviour:
- Reset: miso=0, spiWrStrobe=0, spiWrAddr=0, spiWrData=0, hostRdData=0, busy=0; FSM to IDLE; shift and bit counters cleared. Register contents are not reset.
- Input synchronisation: 2-flop synchroniser on each of cs, sck, mosi, then 1-flop edge detect. Pin-to-event latency is 3 clk.
- Edge mapping: sample/shift edges derive from CPOL/CPHA. mosi is captured on sample edges; miso is updated on shift edges.
- FSM IDLE -> CMD: on cs falling edge. Clear bit counter; shift register = 0.
- FSM CMD: after DATA_W sample edges, decode the command frame:
  - bit DATA_W-1: 1 = write, 0 = read.
  - bits ADDR_W-1:0: start address; remaining bits ignored.
  - Next state DATA_WR or DATA_RD.
  - On read, load mem[addr] into the tx shift register in the same clk, so its MSB drives miso from the next shift edge (CPHA=0) or the first shift edge of the frame (CPHA=1).
- FSM DATA_WR: each completed DATA_W-bit frame writes mem[addr] on the next clk.
  - spiWrStrobe pulses for 1 clk with spiWrAddr/spiWrData.
  - addr increments.
- FSM DATA_RD: at each frame completion, addr increments and mem[addr+1] is loaded for the next frame.
- miso is 0 throughout CMD and DATA_WR.
- Address wrap: DEPTH-1 increments to 0.
- cs rising edge in any state: to IDLE. A partial frame is discarded with no write and no strobe; miso=0.
- Reset asserted mid-transfer: immediate abort, same as reset; no partial write.
- Host port: hostRdData = mem[hostAddr], 1-clk latency. hostWe writes on the clk edge.
- Collision: an SPI write and hostWe in the same clk → the SPI write wins for the same address. Different addresses: both writes complete in that clk (2 write ports, or SPI priority with host write delayed 1 clk; externally both must land).
- Host write vs. SPI read: an SPI read observes host writes completed before its frame load.

Optional Feature:
- Macro: SPI_ADDR_AUTOINC_EN.
- Defined: burst auto-increment and wrap as above.
- Undefined: addr stays fixed for the whole transaction.
  - A repeated write frame overwrites the same register, with a strobe each time.
  - Repeated read frames return the same register, reloaded each frame so host updates are visible.

Test Plan:
- Mode 0, DATA_W=8: send 0x85 then 0x3C, cs high -> mem[5]=0x3C; one spiWrStrobe with spiWrAddr=5, spiWrData=0x3C.
- Read burst: preload mem[5..7]=0x11,0x22,0x33 via host; send 0x05 plus 3 dummy bytes -> miso returns 0x11,0x22,0x33.
- Wrap: write burst starting at addr 127 with 0xAA,0xBB -> mem[127]=0xAA, mem[0]=0xBB. With SPI_ADDR_AUTOINC_EN undefined -> mem[127]=0xBB, mem[0] unchanged.
- Abort: cs high after 4 bits of a write data frame -> no strobe, target register unchanged, next transaction decodes normally.
- Modes 1/2/3 sweep: repeat the read-burst scenario for each CPOL/CPHA -> identical data; also cover reset_n low mid-frame -> all outputs 0, no write.
- Collision: SPI write 0x55 to addr 9 and hostWe 0x66 to addr 9 in the same clk -> mem[9]=0x55; hostRdData shows 0x55 one clk after hostAddr=9.

Source files
------------

// File: rtl/spi_regfile_peripheral.sv
// SPI slave register file on one system clock: oversampled cs/sck/mosi, all four SPI modes,
// read/write bursts and a host parallel port. Macro SPI_ADDR_AUTOINC_EN enables burst address auto-increment.
module spi_regfile_peripheral #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7,
    parameter int CPOL   = 0,
    parameter int CPHA   = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cs,
    input  logic              sck,
    input  logic              mosi,
    output logic              miso,
    input  logic [ADDR_W-1:0] hostAddr,
    input  logic [DATA_W-1:0] hostWrData,
    input  logic              hostWe,
    output logic [DATA_W-1:0] hostRdData,
    output logic              spiWrStrobe,
    output logic [ADDR_W-1:0] spiWrAddr,
    output logic [DATA_W-1:0] spiWrData,
    output logic              busy
);

    localparam int               DEPTH    = 2 ** ADDR_W;
    localparam int               CNT_W    = $clog2(DATA_W);
    localparam logic             CPOL_B   = (CPOL != 0);
    localparam logic             CPHA_B   = (CPHA != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CMD     = 2'd1,
        ST_DATA_WR = 2'd2,
        ST_DATA_RD = 2'd3
    } state_t;

    logic [DATA_W-1:0] mem_r [DEPTH];

    logic [1:0]        cs_sync_r;
    logic [1:0]        sck_sync_r;
    logic [1:0]        mosi_sync_r;
    logic              cs_prev_r;
    logic              sck_prev_r;

    state_t            state_r;
    state_t            state_s;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic [CNT_W-1:0]  bit_cnt_s;
    logic [DATA_W-2:0] rx_shift_r;
    logic [DATA_W-2:0] rx_shift_s;
    logic [DATA_W-1:0] tx_shift_r;
    logic [DATA_W-1:0] tx_shift_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] addr_s;
    logic [ADDR_W-1:0] addr_next_s;
    logic [ADDR_W-1:0] cmd_addr_s;
    logic              miso_r;
    logic              miso_s;

    logic              spi_we_s;
    logic [ADDR_W-1:0] spi_wa_s;
    logic [DATA_W-1:0] spi_wd_s;
    logic [DATA_W-1:0] frame_s;

    logic              strobe_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [DATA_W-1:0] wr_data_r;
    logic [DATA_W-1:0] host_rd_r;
    logic              busy_r;

    logic              sck_rise_s;
    logic              sck_fall_s;
    logic              lead_s;
    logic              trail_s;
    logic              sample_s;
    logic              shift_s;
    logic              cs_fall_s;
    logic              cs_high_s;
    logic              frame_done_s;

    assign sck_rise_s   = sck_sync_r[1] & ~sck_prev_r;
    assign sck_fall_s   = ~sck_sync_r[1] & sck_prev_r;
    assign lead_s       = CPOL_B ? sck_fall_s : sck_rise_s;
    assign trail_s      = CPOL_B ? sck_rise_s : sck_fall_s;
    assign sample_s     = CPHA_B ? trail_s : lead_s;
    assign shift_s      = CPHA_B ? lead_s : trail_s;
    assign cs_fall_s    = cs_prev_r & ~cs_sync_r[1];
    assign cs_high_s    = cs_sync_r[1];
    assign frame_s      = {rx_shift_r, mosi_sync_r[1]};
    assign frame_done_s = sample_s && (bit_cnt_r == CNT_LAST);
    assign cmd_addr_s   = frame_s[ADDR_W-1:0];

`ifdef SPI_ADDR_AUTOINC_EN
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    // Natural ADDR_W-bit overflow gives the DEPTH-1 -> 0 wrap
    assign addr_next_s = addr_r + ADDR_ONE;
`else
    assign addr_next_s = addr_r;
`endif

    // Two-flop synchronisers plus previous-value flops for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_sync_r   <= 2'b11;
            cs_prev_r   <= 1'b1;
            sck_sync_r  <= {2{CPOL_B}};
            sck_prev_r  <= CPOL_B;
            mosi_sync_r <= 2'b00;
        end else begin
            cs_sync_r   <= {cs_sync_r[0], cs};
            cs_prev_r   <= cs_sync_r[1];
            sck_sync_r  <= {sck_sync_r[0], sck};
            sck_prev_r  <= sck_sync_r[1];
            mosi_sync_r <= {mosi_sync_r[0], mosi};
        end
    end

    // Next-state, shift-path and SPI write-request logic
    always_comb begin
        state_s    = state_r;
        bit_cnt_s  = bit_cnt_r;
        rx_shift_s = rx_shift_r;
        tx_shift_s = tx_shift_r;
        addr_s     = addr_r;
        miso_s     = miso_r;
        spi_we_s   = 1'b0;
        spi_wa_s   = addr_r;
        spi_wd_s   = frame_s;
        if (state_r == ST_IDLE) begin
            miso_s = 1'b0;
            if (cs_fall_s) begin
                state_s    = ST_CMD;
                bit_cnt_s  = {CNT_W{1'b0}};
                rx_shift_s = {(DATA_W-1){1'b0}};
                tx_shift_s = {DATA_W{1'b0}};
            end else begin
                state_s = ST_IDLE;
            end
        end else if (cs_high_s) begin
            // Deselect aborts whatever is in flight; a partial frame never reaches the write port
            state_s    = ST_IDLE;
            bit_cnt_s  = {CNT_W{1'b0}};
            rx_shift_s = {(DATA_W-1){1'b0}};
            tx_shift_s = {DATA_W{1'b0}};
            miso_s     = 1'b0;
        end else begin
            if (sample_s) begin
                rx_shift_s = frame_s[DATA_W-2:0];
                bit_cnt_s  = frame_done_s ? {CNT_W{1'b0}} : (bit_cnt_r + CNT_ONE);
            end else begin
                rx_shift_s = rx_shift_r;
            end
            case (state_r)
                ST_CMD: begin
                    miso_s = 1'b0;
                    if (frame_done_s) begin
                        addr_s = cmd_addr_s;
                        if (frame_s[DATA_W-1]) begin
                            state_s = ST_DATA_WR;
                        end else begin
                            state_s    = ST_DATA_RD;
                            tx_shift_s = mem_r[cmd_addr_s];
                        end
                    end else begin
                        state_s = ST_CMD;
                    end
                end
                ST_DATA_WR: begin
                    miso_s = 1'b0;
                    if (frame_done_s) begin
                        spi_we_s = 1'b1;
                        addr_s   = addr_next_s;
                    end else begin
                        spi_we_s = 1'b0;
                    end
                end
                ST_DATA_RD: begin
                    // Sample and shift edges are opposite sck edges, so they never coincide
                    if (shift_s) begin
                        miso_s     = tx_shift_r[DATA_W-1];
                        tx_shift_s = {tx_shift_r[DATA_W-2:0], 1'b0};
                    end else if (frame_done_s) begin
                        addr_s     = addr_next_s;
                        tx_shift_s = mem_r[addr_next_s];
                    end else begin
                        tx_shift_s = tx_shift_r;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    miso_s  = 1'b0;
                end
            endcase
        end
    end

    // FSM state, shift registers and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= {CNT_W{1'b0}};
            rx_shift_r <= {(DATA_W-1){1'b0}};
            tx_shift_r <= {DATA_W{1'b0}};
            addr_r     <= {ADDR_W{1'b0}};
            miso_r     <= 1'b0;
            strobe_r   <= 1'b0;
            wr_addr_r  <= {ADDR_W{1'b0}};
            wr_data_r  <= {DATA_W{1'b0}};
            host_rd_r  <= {DATA_W{1'b0}};
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            bit_cnt_r  <= bit_cnt_s;
            rx_shift_r <= rx_shift_s;
            tx_shift_r <= tx_shift_s;
            addr_r     <= addr_s;
            miso_r     <= miso_s;
            strobe_r   <= spi_we_s;
            if (spi_we_s) begin
                wr_addr_r <= spi_wa_s;
                wr_data_r <= spi_wd_s;
            end
            busy_r     <= ~cs_high_s;
            host_rd_r  <= mem_r[hostAddr];
        end
    end

    // Register file: the SPI write is issued last so it wins a same-address collision
    always_ff @(posedge clk) begin
        if (hostWe) begin
            mem_r[hostAddr] <= hostWrData;
        end
        if (spi_we_s) begin
            mem_r[spi_wa_s] <= spi_wd_s;
        end
    end

    assign miso        = miso_r;
    assign spiWrStrobe = strobe_r;
    assign spiWrAddr   = wr_addr_r;
    assign spiWrData   = wr_data_r;
    assign hostRdData  = host_rd_r;
    assign busy        = busy_r;

endmodule
